// File: rtl/multi_debounce.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter and
// 4-state FSM with separate rise/fall debounce times and registered
// one-cycle rise/fall strobes.
module multi_debounce #(
  parameter int                NUM_CH      = 4,
  parameter int                RISE_CYCLES = 500000,
  parameter int                FALL_CYCLES = 500000,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] INIT_VAL    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] noisy,
  output logic [NUM_CH-1:0] debounced,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_change
);

  localparam int MAX_CYC = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] deb_q, deb_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic              any_q, any_d;
  logic [NUM_CH-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain: stage 0 captures the raw inputs.
  always_comb begin
    sync_d[0] = noisy;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel FSM next-state, counter and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOW: begin
          deb_d[i] = 1'b0;
          if (s[i]) begin
            state_d[i] = ST_WAIT_HIGH;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RISE_LAST) begin
            state_d[i] = ST_HIGH;
            deb_d[i]   = 1'b1;
            rise_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          deb_d[i] = 1'b1;
          if (!s[i]) begin
            state_d[i] = ST_WAIT_LOW;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == FALL_LAST) begin
            state_d[i] = ST_LOW;
            deb_d[i]   = 1'b0;
            fall_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          // Safe recovery from a corrupted encoding.
          state_d[i] = ST_LOW;
          deb_d[i]   = 1'b0;
          cnt_d[i]   = '0;
        end
      endcase
    end
    any_d = |(rise_d | fall_d);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INIT_VAL;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= INIT_VAL[i] ? ST_HIGH : ST_LOW;
        cnt_q[i]   <= '0;
      end
      deb_q  <= INIT_VAL;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign debounced  = deb_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed testbench for multi_debounce (RISE=8, FALL=4, SYNC=2).
module tb_multi_debounce;

  logic       clk;
  logic       rst_n, rst2_n;
  logic [3:0] noisy, noisy2;
  logic [3:0] deb, rise, fall, deb2, rise2, fall2;
  logic       anyc, anyc2;

  int n_checks = 0;
  int n_fail   = 0;

  multi_debounce #(
    .NUM_CH(4), .RISE_CYCLES(8), .FALL_CYCLES(4), .SYNC_STAGES(2), .INIT_VAL(4'b0000)
  ) dut (
    .clk(clk), .reset(rst_n), .noisy(noisy),
    .debounced(deb), .rise(rise), .fall(fall), .any_change(anyc)
  );

  multi_debounce #(
    .NUM_CH(4), .RISE_CYCLES(8), .FALL_CYCLES(4), .SYNC_STAGES(2), .INIT_VAL(4'b1010)
  ) dut_init (
    .clk(clk), .reset(rst2_n), .noisy(noisy2),
    .debounced(deb2), .rise(rise2), .fall(fall2), .any_change(anyc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic       seen;
  logic [3:0] strobe_acc;

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    noisy  = 4'b0000;
    noisy2 = 4'b1010;
    step(2);
    check("reset_deb",  deb,  4'b0000);
    check("reset_rise", rise, 4'b0000);
    check("reset_fall", fall, 4'b0000);
    check("reset_any",  anyc, 1'b0);
    check("init_reset_deb", deb2, 4'b1010);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    step(3);

    // Clean rise on channel 0: debounced at edge 10.
    noisy = 4'b0001;
    step(9);
    check("rise0_before", deb, 4'b0000);
    step(1);
    check("rise0_deb",  deb,  4'b0001);
    check("rise0_rise", rise, 4'b0001);
    check("rise0_fall", fall, 4'b0000);
    check("rise0_any",  anyc, 1'b1);
    step(1);
    check("rise0_rise_after", rise, 4'b0000);
    check("rise0_any_after",  anyc, 1'b0);
    check("rise0_deb_hold",   deb,  4'b0001);

    // Glitch reject on channel 1: 7-cycle high run.
    noisy = 4'b0011;
    step(7);
    noisy = 4'b0001;
    strobe_acc = '0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      strobe_acc |= rise | fall;
    end
    check("glitch1_deb",     deb,        4'b0001);
    check("glitch1_strobes", strobe_acc, 4'b0000);
    noisy = 4'b0011;
    step(9);
    check("rise1_before", deb, 4'b0001);
    step(1);
    check("rise1_deb",  deb,  4'b0011);
    check("rise1_rise", rise, 4'b0010);

    // Asymmetric fall on channel 2.
    noisy = 4'b0111;
    step(12);
    check("ch2_high", deb, 4'b0111);
    noisy = 4'b0011;
    step(5);
    check("fall2_before", deb, 4'b0111);
    step(1);
    check("fall2_deb",  deb,  4'b0011);
    check("fall2_fall", fall, 4'b0100);
    check("fall2_rise", rise, 4'b0000);
    check("fall2_any",  anyc, 1'b1);
    step(1);
    check("fall2_fall_after", fall, 4'b0000);
    noisy = 4'b0111;
    step(12);
    check("ch2_high_again", deb, 4'b0111);
    noisy = 4'b0011;
    step(3);
    noisy = 4'b0111;
    strobe_acc = '0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      strobe_acc |= rise | fall;
    end
    check("blip2_deb",     deb,        4'b0111);
    check("blip2_strobes", strobe_acc, 4'b0000);

    // Simultaneous rise on all channels.
    noisy = 4'b0000;
    step(10);
    check("all_low", deb, 4'b0000);
    noisy = 4'b1111;
    step(9);
    check("all_before", deb, 4'b0000);
    step(1);
    check("all_deb",  deb,  4'b1111);
    check("all_rise", rise, 4'b1111);
    check("all_any",  anyc, 1'b1);
    step(1);
    check("all_rise_after", rise, 4'b0000);

    // Asynchronous reset from HIGH clears outputs before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_deb", deb, 4'b0000);
    step(2);
    rst_n = 1'b1;
    step(9);
    check("post_rst_before", deb, 4'b0000);
    step(1);
    check("post_rst_deb",  deb,  4'b1111);
    check("post_rst_rise", rise, 4'b1111);

    // Reset mid-count aborts the count; full latency after release.
    noisy = 4'b0000;
    step(10);
    noisy = 4'b1111;
    step(5);
    rst_n = 1'b0;
    #1;
    check("midrst_deb",  deb,  4'b0000);
    check("midrst_rise", rise, 4'b0000);
    check("midrst_any",  anyc, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(9);
    check("midrst_full_before", deb, 4'b0000);
    step(1);
    check("midrst_full_deb",  deb,  4'b1111);
    check("midrst_full_rise", rise, 4'b1111);

    // INIT_VAL build: held inputs matching INIT_VAL produce no strobes.
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if ((rise2 | fall2) != 4'b0000 || anyc2) seen = 1'b1;
    end
    check("init_no_strobes", seen, 1'b0);
    check("init_deb_hold",   deb2, 4'b1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
Parametrised multi-channel debouncer for buttons, switches and other noisy asynchronous inputs. Each channel has its own input synchroniser, its own stability counter and its own 4-state FSM. Rise and fall debounce times are set separately. Per-channel one-cycle rise/fall strobes are provided, so downstream FSMs need no separate edge detectors. It replaces single-channel debounce-plus-external-timer instances at the top level.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
RISE_CYCLES, 500000, consecutive high samples required before debounced goes 1 (>=2)
FALL_CYCLES, 500000, consecutive low samples required before debounced goes 0 (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
INIT_VAL, {NUM_CH{1'b0}}, per-channel debounced value held in reset
CNT_W, $clog2(max(RISE_CYCLES,FALL_CYCLES)+1), counter width (derived; not overridden)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
noisy  input  NUM_CH  raw asynchronous inputs
debounced  output  NUM_CH  stable filtered level per channel
rise  output  NUM_CH  one-cycle strobe when debounced[i] goes 0->1
fall  output  NUM_CH  one-cycle strobe when debounced[i] goes 1->0
any_change  output  1  OR of all rise and fall bits, same cycle

Behaviour:
- Reset (reset==0, asynchronous assert; deassert is synchronous to clk in the system):
  - sync flops[i] = INIT_VAL[i]; debounced = INIT_VAL
  - state[i] = HIGH if INIT_VAL[i] else LOW; counters = 0
  - rise = fall = 0; any_change = 0
- Synchroniser: noisy[i] passes through SYNC_STAGES flops; the final stage is s[i]. The FSM only sees s[i].
- Per-channel FSM, all outputs registered:
  - LOW (debounced=0): s=1 -> WAIT_HIGH, cnt<=1; s=0 -> stay, cnt<=0
  - WAIT_HIGH (debounced=0):
    - s=0 -> LOW, cnt<=0 (glitch rejected, no strobe)
    - s=1 and cnt==RISE_CYCLES-1 -> HIGH, debounced<=1, rise<=1, cnt<=0
    - s=1 otherwise -> cnt<=cnt+1
  - HIGH (debounced=1): s=0 -> WAIT_LOW, cnt<=1; s=1 -> stay
  - WAIT_LOW: mirror of WAIT_HIGH, using FALL_CYCLES and driving fall
  - Illegal encoding -> LOW with cnt<=0 (safe recovery; no X-propagating default)
- Latency: edge 1 is the first clock edge that samples noisy[i] at its new level. With the input stable from edge 1, debounced[i] changes at edge SYNC_STAGES+RISE_CYCLES (rising) or SYNC_STAGES+FALL_CYCLES (falling).
- Strobes:
  - rise/fall are high exactly one cycle, coincident with the debounced transition cycle
  - rise[i] and fall[i] are never high together
  - any_change is registered alongside them
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.
- Any level interruption restarts the count from zero. A run of N<RISE_CYCLES high samples causes no output change.
- Reset asserted mid-WAIT aborts the count. After release, a full count is required.
- Counter never exceeds max(RISE_CYCLES,FALL_CYCLES)-1; no wrap-around is possible.

Test Plan:
Config for all tests: NUM_CH=4, RISE_CYCLES=8, FALL_CYCLES=4, SYNC_STAGES=2, INIT_VAL=0.
- Clean rise: noisy[0] 0->1 held -> debounced[0]=1 at edge 10. rise[0]=1 for exactly that one cycle; any_change=1 in the same cycle; other channels unchanged.
- Glitch reject: noisy[1] high for 7 cycles then low -> debounced[1] stays 0, no rise/fall. A subsequent 8-cycle high run -> debounced[1]=1 at edge 10 of that run.
- Asymmetric fall: debounced[2]=1, then noisy[2] 1->0 held -> debounced[2]=0 at edge 6 with one fall[2] pulse. A 3-cycle low blip -> no change.
- Simultaneous channels: noisy=4'b1111 in one cycle -> all four debounced bits rise at the same edge 10; rise=4'b1111 for one cycle.
- Reset mid-count:
  - reset=0 at edge 5 of a rise count -> debounced=0 and strobes=0 immediately (asynchronous)
  - after release with noisy held high -> full 10-edge latency again
- INIT_VAL=4'b1010 build: during reset debounced=4'b1010. After release with noisy=4'b1010 held, no strobes for 100 cycles.
